// File: rtl/seq_divider.sv
// seq_divider -- multi-cycle signed 32-bit divider for the DIV instruction.
//
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// clock, followed by a sign-correction step. Truncating semantics: the
// quotient rounds toward zero and the remainder takes the dividend's sign.
// A zero divisor skips the iterations and reports div_by_zero with
// quotient = all ones and remainder = dividend.
//
// Ports:
//   clk          system clock, rising edge
//   clr          asynchronous active-high reset
//   start        request a division (sampled only in IDLE)
//   dividend     signed dividend (sampled on the accepting edge)
//   divisor      signed divisor  (sampled on the accepting edge)
//   busy         high in every state except IDLE
//   done         one-cycle pulse, results valid while high
//   quotient     signed quotient, held until the next result
//   remainder    signed remainder, held until the next result
//   div_by_zero  set with done when divisor was zero, cleared on next accept
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  // r_dq starts as |dividend| and becomes |quotient| as bits shift in.
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_prem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH-1:0] w_abs_dvs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;

  // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
  assign w_abs_dvd = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign w_abs_dvs = divisor[WIDTH-1]  ? (~divisor  + 1'b1) : divisor;

  // Partial remainder is always below the divisor magnitude, so its low
  // WIDTH bits hold it; the shifted value needs the extra top bit.
  assign w_shift = {r_prem[WIDTH-1:0], r_dq[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_trial[WIDTH];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dq    <= '0;
      r_dvs   <= '0;
      r_prem  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dbz <= 1'b0;
            if (divisor == '0) begin
              r_quo   <= '1;
              r_rem   <= dividend;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_dq    <= w_abs_dvd;
              r_dvs   <= w_abs_dvs;
              r_neg_r <= dividend[WIDTH-1];
              r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_prem  <= '0;
              r_cnt   <= '0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_prem <= w_fits ? w_trial : w_shift;
          r_dq   <= {r_dq[WIDTH-2:0], w_fits};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          r_quo   <= r_neg_q ? (~r_dq + 1'b1) : r_dq;
          r_rem   <= r_neg_r ? (~r_prem[WIDTH-1:0] + 1'b1) : r_prem[WIDTH-1:0];
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Decoded from state only, so no input reaches an output combinationally.
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          at;   // cycle count seen at the negedge where done is expected
  } exp_t;

  exp_t scb[$];
  int checks = 0;
  int errors = 0;
  int ndone  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: truncating signed division on 64-bit integers, so the
  // -2^31 / -1 case simply wraps when narrowed back to 32 bits.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int at);
    exp_t   e;
    longint sa, sd, q, r;
    e.at = at;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      q  = sa / sd;
      r  = sa - q * sd;
      e.q = q[31:0]; e.r = r[31:0]; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  exp_t m_e;
  always @(negedge clk) begin
    if (!clr && done) begin
      ndone++;
      if (scb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done: done=1 with no accepted request (t=%0t)", $time);
      end else begin
        m_e = scb.pop_front();
        chk("quotient",    quotient,           m_e.q);
        chk("remainder",   remainder,          m_e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_e.dbz});
        chk("done_cycle",  cyc,                m_e.at);
        chk("busy_in_done", {31'd0, busy},     32'd1);
      end
    end
  end

  // Present one request for a single edge; pushes an expectation only when
  // the DUT is idle and will accept it. Returns just after that edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output bit acc);
    @(negedge clk);
    acc = !busy;
    start = 1'b1; dividend = a; divisor = b;
    if (acc) scb.push_back(model(a, b, cyc + 1 + ((b != 0) ? 33 : 0)));
    @(posedge clk);
    #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles expected 0", busy, n);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    bit acc;
    issue(a, b, acc);
    chk("accepted", {31'd0, acc}, 32'd1);
    wait_idle();
  endtask

  initial begin
    bit          acc;
    int          bc, n, nd0;
    logic [31:0] a, b;
    logic [31:0] ext [6];
    ext[0] = 32'h8000_0000; ext[1] = 32'hFFFF_FFFF; ext[2] = 32'h7FFF_FFFF;
    ext[3] = 32'h0000_0001; ext[4] = 32'h0000_0000; ext[5] = 32'h8000_0001;

    clr = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q",    quotient,      32'd0);
    chk("rst_r",    remainder,     32'd0);
    chk("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
    clr = 1'b0;

    // 100 / 7 with busy-window measurement
    issue(32'd100, 32'd7, acc);
    chk("accept_100_7", {31'd0, acc}, 32'd1);
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
    end
    chk("busy_cycles", bc, 34);

    run(-32'sd100, 32'd7);
    run(32'd100, -32'sd7);
    run(-32'sd100, -32'sd7);
    run(32'h8000_0000, 32'hFFFF_FFFF);
    run(32'hFFFF_FFFF, 32'h8000_0000);
    run(32'd0, 32'd5);

    // divide by zero, then results hold and flag clears on the next accept
    run(32'd55, 32'd0);
    issue(32'd9, 32'd3, acc);
    chk("accept_9_3", {31'd0, acc}, 32'd1);
    chk("dbz_clear_at_accept", {31'd0, div_by_zero}, 32'd0);
    chk("q_hold_in_run", quotient,  32'hFFFF_FFFF);
    chk("r_hold_in_run", remainder, 32'd55);
    wait_idle();

    // start while busy: at E10 and during DONE, both ignored
    nd0 = ndone;
    issue(32'd100, 32'd7, acc);
    repeat (9) @(negedge clk);
    start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done && n < 60) begin @(negedge clk); n++; end
    start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1; start = 1'b0;
    issue(32'd8, 32'd2, acc);
    chk("accept_after_done", {31'd0, acc}, 32'd1);
    wait_idle();
    chk("done_pulses", ndone - nd0, 2);

    // reset in the middle of a run
    issue(32'd1000, 32'd3, acc);
    nd0 = ndone;
    repeat (10) @(posedge clk);
    #2 clr = 1'b1;
    scb.delete();
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_q",    quotient,      32'd0);
    chk("midrst_r",    remainder,     32'd0);
    @(negedge clk); clr = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", ndone - nd0, 0);
    run(32'd81, 32'd9);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 5))
        0: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
        1: begin a = $urandom; b = $urandom; end
        2: begin a = $urandom; b = 32'd0; end
        3: begin a = ext[$urandom_range(0, 5)]; b = ext[$urandom_range(0, 5)]; end
        4: begin a = $urandom; b = ($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFF_FFFF; end
        default: begin a = $urandom; b = $urandom_range(0, 255) - 128; end
      endcase
      run(a, b);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", scb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
